// File: rtl/ppu_pkg.sv
// Shared PPU types and CPU register addresses used by the OAM DMA writer.
package ppu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] REG_OAMADDR = 16'h2003;
    localparam logic [15:0] REG_OAMDATA = 16'h2004;
    localparam logic [15:0] REG_OAMDMA  = 16'h4014;

endpackage

// File: rtl/ppu_oam_dma.sv
// CPU-side OAM writer: $2003/$2004 register writes and the $4014 page DMA into primary OAM.
// Define OAM_DMA_ALIGN_EN to insert the odd-cycle ALIGN stall before the first DMA read.
module ppu_oam_dma
    import ppu_pkg::*;
#(
    parameter int PAGE_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    output logic        cpu_rdy,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        oam_dma
);

    localparam logic [7:0] LAST_CNT = 8'(PAGE_BYTES - 1);

    dma_state_t state;
    dma_state_t next_state;
    logic [7:0] oamaddr;
    logic [7:0] page;
    logic [7:0] cnt;
`ifdef OAM_DMA_ALIGN_EN
    logic       parity;
`endif

    // State and registers; everything except the one-clk oam_dma strobe moves only on cpu_ce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            oamaddr  <= 8'h00;
            page     <= 8'h00;
            cnt      <= 8'h00;
            oam_addr <= 8'h00;
            oam_data <= 8'h00;
            oam_dma  <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
            parity   <= 1'b0;
`endif
        end else begin
            oam_dma <= 1'b0;
            if (cpu_ce) begin
                state <= next_state;
`ifdef OAM_DMA_ALIGN_EN
                parity <= ~parity;
`endif
                unique case (state)
                    IDLE: begin
                        if (cpu_wr) begin
                            if (cpu_addr == REG_OAMADDR) begin
                                oamaddr <= cpu_wdata;
                            end else if (cpu_addr == REG_OAMDATA) begin
                                oam_addr <= oamaddr;
                                oam_data <= cpu_wdata;
                                oam_dma  <= 1'b1;
                                oamaddr  <= oamaddr + 8'd1;
                            end else if (cpu_addr == REG_OAMDMA) begin
                                page <= cpu_wdata;
                                cnt  <= 8'h00;
                            end
                        end
                    end
                    // The edge closing READ is the first edge of WRITE: latch the byte and strobe.
                    READ: begin
                        oam_data <= mem_rdata;
                        oam_addr <= oamaddr + cnt;
                        oam_dma  <= 1'b1;
                    end
                    WRITE: begin
                        cnt <= cnt + 8'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (cpu_wr && cpu_addr == REG_OAMDMA) begin
                    next_state = HALT;
                end
            end
            HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                // parity is the current cycle; an even HALT means the following cycle is odd.
                next_state = parity ? READ : ALIGN;
`else
                next_state = READ;
`endif
            end
            ALIGN: next_state = READ;
            READ:  next_state = WRITE;
            WRITE: next_state = (cnt == LAST_CNT) ? IDLE : READ;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cpu_rdy  = (state == IDLE);
        dma_rd   = (state == READ);
        dma_addr = dma_rd ? {page, cnt} : 16'h0000;
    end

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Randomized bench for ppu_oam_dma against a register/OAM-write reference model.
`timescale 1ns/1ps
module tb_ppu_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_ce;
    logic        cpu_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  mem_rdata;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic        cpu_rdy;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        oam_dma;

    ppu_oam_dma dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_ce    (cpu_ce),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .mem_rdata (mem_rdata),
        .dma_addr  (dma_addr),
        .dma_rd    (dma_rd),
        .cpu_rdy   (cpu_rdy),
        .oam_addr  (oam_addr),
        .oam_data  (oam_data),
        .oam_dma   (oam_dma)
    );

    always #5 clk = ~clk;

    // Reference model: OAMADDR, expected OAM writes {addr,data}, DMA page/memory key.
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  m_oamaddr = 8'h00;
    logic [7:0]  m_page = 8'h00;
    logic [7:0]  mem_key = 8'h00;
    logic [15:0] exp_q[$];
    int          ce_total = 0;
    int          rd_idx = 0;
    int          pulses = 0;
    logic        dma_prev = 1'b0;

    // Page memory: byte i of every page reads as i ^ mem_key.
    assign mem_rdata = dma_addr[7:0] ^ mem_key;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cpu_cycle(input logic wr, input logic [15:0] a, input logic [7:0] d);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        cpu_ce    = 1'b1;
        cpu_wr    = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        @(posedge clk);
        #1;
        cpu_ce    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = 16'($urandom);
        cpu_wdata = 8'($urandom);
        ce_total++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cpu_cycle(1'b0, 16'($urandom), 8'($urandom));
    endtask

    task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
        if (a == 16'h2003) begin
            m_oamaddr = d;
        end else if (a == 16'h2004) begin
            exp_q.push_back({m_oamaddr, d});
            m_oamaddr = m_oamaddr + 8'd1;
        end
        cpu_cycle(1'b1, a, d);
    endtask

    task automatic do_reset();
        #1;
        reset  = 1'b1;
        cpu_ce = 1'b0;
        cpu_wr = 1'b0;
        exp_q.delete();
        m_oamaddr = 8'h00;
        ce_total  = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Issue $4014 and run the CPU until it is released; stop_at >= 0 returns after that many OAM writes.
    task automatic run_dma(input logic [7:0] pg, input logic [7:0] key, input bit meddle, input int stop_at);
        int low;
        int exp_low;
        int start_pulses;
        mem_key = key;
        m_page  = pg;
        rd_idx  = 0;
        for (int i = 0; i < 256; i++) exp_q.push_back({8'(m_oamaddr + 8'(i)), 8'(i) ^ key});
        cpu_cycle(1'b1, 16'h4014, pg);
`ifdef OAM_DMA_ALIGN_EN
        exp_low = (ce_total % 2 == 0) ? 514 : 513;
`else
        exp_low = 513;
`endif
        check("rdy_low_after_4014", cpu_rdy, 0);
        start_pulses = pulses;
        low = 0;
        while (!cpu_rdy && low < 600) begin
            if (stop_at >= 0 && pulses - start_pulses >= stop_at) break;
            if (meddle && $urandom_range(0, 7) == 0)
                cpu_cycle(1'b1, ($urandom_range(0, 1) == 1) ? 16'h2003 : 16'h2004, 8'($urandom));
            else
                cpu_cycle(1'b0, 16'($urandom), 8'($urandom));
            low++;
        end
        if (stop_at < 0) begin
            check("rdy_low_cycles", low, exp_low);
            check("dma_read_count", rd_idx, 256);
            idle(1);
            check("dma_q_drained", exp_q.size(), 0);
        end else begin
            check("pulses_before_reset", pulses - start_pulses, stop_at);
        end
    endtask

    // Scoreboard and bus monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (oam_dma) begin
                    pulses++;
                    check("oam_dma_width", dma_prev, 0);
                    check("oam_pulse_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("oam_write", {oam_addr, oam_data}, exp_q.pop_front());
                end
                dma_prev = oam_dma;
                if (cpu_ce && dma_rd) begin
                    check("dma_addr", dma_addr, {m_page, 8'(rd_idx)});
                    rd_idx++;
                end
            end
        end
    end

    initial begin
        int p0;
        reset     = 1'b1;
        cpu_ce    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dma_addr", dma_addr, 0);
        check("rst_dma_rd", dma_rd, 0);
        check("rst_cpu_rdy", cpu_rdy, 1);
        check("rst_oam_addr", oam_addr, 0);
        check("rst_oam_data", oam_data, 0);
        check("rst_oam_dma", oam_dma, 0);
        do_reset();

        // Register writes: $2003 then two $2004 writes at 10, 11.
        reg_write(16'h2003, 8'h10);
        reg_write(16'h2004, 8'hAB);
        reg_write(16'h2004, 8'($urandom));
        idle(2);
        check("reg_q_drained", exp_q.size(), 0);

        // Page 2 DMA, memory[i] = i ^ 5A.
        run_dma(8'h02, 8'h5A, 1'b0, -1);

        // DMA wrapping from OAMADDR F0; OAMADDR survives the transfer.
        reg_write(16'h2003, 8'hF0);
        run_dma(8'($urandom), 8'($urandom), 1'b0, -1);
        reg_write(16'h2004, 8'($urandom));
        idle(2);
        check("oamaddr_after_dma", exp_q.size(), 0);

        // $4014 on each parity.
        if (ce_total % 2 == 0) idle(1);
        run_dma(8'($urandom), 8'($urandom), 1'b0, -1);
        if (ce_total % 2 == 1) idle(1);
        run_dma(8'($urandom), 8'($urandom), 1'b0, -1);

        // Reset after the 100th DMA write.
        reg_write(16'h2003, 8'($urandom));
        run_dma(8'($urandom), 8'($urandom), 1'b0, 100);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_cpu_rdy", cpu_rdy, 1);
        check("midrst_dma_rd", dma_rd, 0);
        check("midrst_oam_dma", oam_dma, 0);
        exp_q.delete();
        m_oamaddr = 8'h00;
        ce_total  = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        p0 = pulses;
        idle(20);
        check("no_pulses_after_reset", pulses - p0, 0);
        run_dma(8'($urandom), 8'($urandom), 1'b0, -1);

        // Register writes during DMA are ignored.
        reg_write(16'h2003, 8'($urandom));
        run_dma(8'($urandom), 8'($urandom), 1'b1, -1);
        reg_write(16'h2004, 8'($urandom));

        // Random register traffic.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: reg_write(16'h2003, 8'($urandom));
                1: reg_write(16'h2004, 8'($urandom));
                default: idle(1);
            endcase
        end
        idle(3);
        check("final_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
